decode_pipe_stage: RTL and testbench
====================================

DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 Parameters (one per line: name, default, meaning):
 WORD_WIDTH, 32, datapath/PC/instruction width
 REG_ADDR_WIDTH, 4, register index width; register count = 2**REG_ADDR_WIDTH
 CTRL_WIDTH, 7, opaque control bundle width (excludes wb_en/mem_read)
 FORWARDING_EN, 0, 0 = stall on any RAW; 1 = stall on load-use only
REQ-003 Ports (name, direction, width, meaning):
 clk  in  1  clock, rising edge
 rst  in  1  asynchronous active-low reset
 id_valid  in  1  decode-stage instruction present
 id_ready  out  1  instruction accepted this cycle
 pc_in, instruction_in  in  WORD_WIDTH  fetched PC/instruction
 src1_addr, src2_addr, dst_addr  in  REG_ADDR_WIDTH  register indices
 src1_used, src2_used  in  1  operand actually read
 ctrl_in  in  CTRL_WIDTH  decoded control bundle
 wb_en_in, mem_read_in  in  1  decoded writeback / load flags
 condition_pass  in  1  condition check result
 flush  in  1  branch-taken squash
 ex_ready  in  1  execute stage accepts
 mem_wb_en  in  1; mem_dst  in  REG_ADDR_WIDTH  memory-stage writer
 wb_en  in  1; wb_addr  in  REG_ADDR_WIDTH; wb_data  in  WORD_WIDTH  register write port
 ex_valid  out  1; ex_pc, ex_instruction, ex_val_rn, ex_val_rm  out  WORD_WIDTH
 ex_dst, ex_src1, ex_src2  out  REG_ADDR_WIDTH; ex_ctrl  out  CTRL_WIDTH
 ex_wb_en, ex_mem_read  out  1
 hazard  out  1  RAW stall asserted

Function
REQ-004 Register file: 2**REG_ADDR_WIDTH x WORD_WIDTH; written on rising clk when wb_en=1, independent of stall/flush.
REQ-005 Reads SHALL be combinational with write bypass: wb_en=1 and wb_addr==srcN_addr returns wb_data same cycle.
REQ-006 Match N (N=1,2) = srcN_used AND address equality with a writer; writers: EX = ex_valid & ex_wb_en & ex_dst; MEM = mem_wb_en & mem_dst.
REQ-007 FORWARDING_EN=0: hazard = id_valid & (EX match or MEM match) on either source.
REQ-008 FORWARDING_EN=1: hazard = id_valid & EX match & ex_mem_read; MEM matches ignored.
REQ-009 slot_free = ~ex_valid | ex_ready; id_ready = flush | (slot_free & ~hazard).
REQ-010 At rising edge, priority: flush -> ex_valid<=0, ID instruction discarded; else if slot_free -> ex_valid <= id_valid & ~hazard, payload loaded when that value is 1; else hold all ex_* outputs.
REQ-011 Loaded payload: pc_in, instruction_in, bypassed reads, dst/src addresses, ctrl_in, wb_en_in, mem_read_in.
REQ-012 condition_pass=0: instruction still advances with ex_valid=1 but ex_ctrl, ex_wb_en, ex_mem_read SHALL be 0.
REQ-013 While ex_valid=1 and ex_ready=0, every ex_* output SHALL be stable.
REQ-014 Latency: accepted instruction appears on ex_* exactly one cycle after acceptance; throughput one per cycle with no hazard.
REQ-015 Stalled instruction re-reads the register file each cycle, picking up writes landed during the stall.

Reset
REQ-016 rst=0 SHALL immediately clear ex_valid, all ex_* outputs and every register to 0, regardless of clk.
REQ-017 First accept possible on first rising edge after rst returns high; in-flight instruction lost at reset.

Verification
REQ-018 Reset: write R3=0x55, assert rst=0 mid-cycle -> ex_valid=0 at once; later read R3 -> 0.
REQ-019 Bypass: wb_en=1, wb_addr=5, wb_data=0xDEAD, id src1_addr=5 -> next cycle ex_val_rn=0xDEAD.
REQ-020 FORWARDING_EN=0: EX holds wb_en dst=2, ID src2_addr=2, src2_used=1 -> hazard=1, id_ready=0; stall continues while MEM dst=2, releases after.
REQ-021 FORWARDING_EN=1: same with ex_mem_read=0 -> no stall; with ex_mem_read=1 -> exactly one stall cycle.
REQ-022 Backpressure: ex_ready=0 three cycles with ex_valid=1 -> ex_* unchanged, id_ready=0; flush then -> ex_valid=0 next edge.
REQ-023 condition_pass=0, wb_en_in=1, ctrl_in=0x7F -> ex_valid=1, ex_wb_en=0, ex_ctrl=0, no hazard raised against its dst.

Source files
------------

// File: rtl/decode_pipe_stage.sv
// ---------------------------------------------------------------------------
// decode_pipe_stage
//
// Decode-to-execute pipeline stage. Holds the architectural register file,
// reads both source operands (with same-cycle write bypass), detects RAW
// hazards against the execute- and memory-stage writers, and registers the
// decoded instruction into the execute slot with valid/ready handshaking.
//
// Parameters
//   WORD_WIDTH      datapath / PC / instruction width
//   REG_ADDR_WIDTH  register index width (2**REG_ADDR_WIDTH registers)
//   CTRL_WIDTH      opaque control bundle width
//   FORWARDING_EN   0: stall on any RAW, 1: stall on load-use only
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   id_valid / id_ready      decode-stage handshake
//   pc_in, instruction_in    fetched PC / instruction
//   src1/src2/dst_addr       register indices; srcN_used marks real reads
//   ctrl_in, wb_en_in,
//   mem_read_in              decoded control
//   condition_pass           0 squashes side effects of this instruction
//   flush                    branch-taken squash of ID and EX slot
//   ex_ready                 execute stage accepts the slot contents
//   mem_wb_en, mem_dst       memory-stage writer (hazard source)
//   wb_en, wb_addr, wb_data  register-file write port
//   ex_*                     execute-slot outputs
//   hazard                   RAW stall asserted this cycle
// ---------------------------------------------------------------------------
module decode_pipe_stage #(
    parameter int WORD_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int CTRL_WIDTH     = 7,
    parameter bit FORWARDING_EN  = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    output logic                      id_ready,
    input  logic [WORD_WIDTH-1:0]     pc_in,
    input  logic [WORD_WIDTH-1:0]     instruction_in,
    input  logic [REG_ADDR_WIDTH-1:0] src1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] src2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] dst_addr,
    input  logic                      src1_used,
    input  logic                      src2_used,
    input  logic [CTRL_WIDTH-1:0]     ctrl_in,
    input  logic                      wb_en_in,
    input  logic                      mem_read_in,
    input  logic                      condition_pass,
    input  logic                      flush,
    input  logic                      ex_ready,
    input  logic                      mem_wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] mem_dst,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [WORD_WIDTH-1:0]     wb_data,
    output logic                      ex_valid,
    output logic [WORD_WIDTH-1:0]     ex_pc,
    output logic [WORD_WIDTH-1:0]     ex_instruction,
    output logic [WORD_WIDTH-1:0]     ex_val_rn,
    output logic [WORD_WIDTH-1:0]     ex_val_rm,
    output logic [REG_ADDR_WIDTH-1:0] ex_dst,
    output logic [REG_ADDR_WIDTH-1:0] ex_src1,
    output logic [REG_ADDR_WIDTH-1:0] ex_src2,
    output logic [CTRL_WIDTH-1:0]     ex_ctrl,
    output logic                      ex_wb_en,
    output logic                      ex_mem_read,
    output logic                      hazard
);

    localparam int REG_COUNT = 2 ** REG_ADDR_WIDTH;

    logic [WORD_WIDTH-1:0] reg_file [REG_COUNT];

    // Execute-slot registers
    logic                      vld_p1;
    logic [WORD_WIDTH-1:0]     pc_p1;
    logic [WORD_WIDTH-1:0]     instr_p1;
    logic [WORD_WIDTH-1:0]     rn_p1;
    logic [WORD_WIDTH-1:0]     rm_p1;
    logic [REG_ADDR_WIDTH-1:0] dst_p1;
    logic [REG_ADDR_WIDTH-1:0] src1_p1;
    logic [REG_ADDR_WIDTH-1:0] src2_p1;
    logic [CTRL_WIDTH-1:0]     ctrl_p1;
    logic                      wb_en_p1;
    logic                      mem_read_p1;

    // Decode-stage combinational signals
    logic [WORD_WIDTH-1:0] rn_p0;
    logic [WORD_WIDTH-1:0] rm_p0;
    logic                  ex_writer;
    logic                  ex_match;
    logic                  mem_match;
    logic                  hazard_p0;
    logic                  slot_free;
    logic                  accept;

    // Register file: the write port is independent of stall and flush so
    // retiring instructions always land.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_file <= '{default: '0};
        end else if (wb_en) begin
            reg_file[wb_addr] <= wb_data;
        end
    end

    // ---- stage p0: operand read, hazard detection, handshake ----

    // A write landing this cycle is visible to the reader at once, so a
    // stalled instruction picks up results that retire during the stall.
    always_comb begin
        rn_p0 = reg_file[src1_addr];
        rm_p0 = reg_file[src2_addr];
        if (wb_en && (wb_addr == src1_addr)) begin
            rn_p0 = wb_data;
        end
        if (wb_en && (wb_addr == src2_addr)) begin
            rm_p0 = wb_data;
        end
    end

    // The EX writer is taken from the registered slot, whose wb_en is already
    // cleared for condition-failed instructions, so those never cause stalls.
    always_comb begin
        ex_writer = vld_p1 & wb_en_p1;
        ex_match  = (src1_used & ex_writer & (dst_p1 == src1_addr))
                  | (src2_used & ex_writer & (dst_p1 == src2_addr));
        mem_match = (src1_used & mem_wb_en & (mem_dst == src1_addr))
                  | (src2_used & mem_wb_en & (mem_dst == src2_addr));
        if (FORWARDING_EN) begin
            // Only a load in EX cannot be forwarded in time.
            hazard_p0 = id_valid & ex_match & mem_read_p1;
        end else begin
            hazard_p0 = id_valid & (ex_match | mem_match);
        end
    end

    assign slot_free = ~vld_p1 | ex_ready;
    assign accept    = id_valid & ~hazard_p0;
    assign id_ready  = flush | (slot_free & ~hazard_p0);
    assign hazard    = hazard_p0;

    // ---- stage p1: execute slot ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            instr_p1    <= '0;
            rn_p1       <= '0;
            rm_p1       <= '0;
            dst_p1      <= '0;
            src1_p1     <= '0;
            src2_p1     <= '0;
            ctrl_p1     <= '0;
            wb_en_p1    <= 1'b0;
            mem_read_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (slot_free) begin
            vld_p1 <= accept;
            if (accept) begin
                pc_p1       <= pc_in;
                instr_p1    <= instruction_in;
                rn_p1       <= rn_p0;
                rm_p1       <= rm_p0;
                dst_p1      <= dst_addr;
                src1_p1     <= src1_addr;
                src2_p1     <= src2_addr;
                // A failed condition still occupies the slot but has no
                // architectural side effects.
                ctrl_p1     <= condition_pass ? ctrl_in : '0;
                wb_en_p1    <= condition_pass & wb_en_in;
                mem_read_p1 <= condition_pass & mem_read_in;
            end
        end
    end

    assign ex_valid       = vld_p1;
    assign ex_pc          = pc_p1;
    assign ex_instruction = instr_p1;
    assign ex_val_rn      = rn_p1;
    assign ex_val_rm      = rm_p1;
    assign ex_dst         = dst_p1;
    assign ex_src1        = src1_p1;
    assign ex_src2        = src2_p1;
    assign ex_ctrl        = ctrl_p1;
    assign ex_wb_en       = wb_en_p1;
    assign ex_mem_read    = mem_read_p1;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_pipe_stage
//
// Drives two instances of decode_pipe_stage from the same inputs: one with
// FORWARDING_EN=0 (index 0) and one with FORWARDING_EN=1 (index 1). A
// behavioural model of each instance is kept in plain arrays and compared
// against the DUTs every cycle; directed scenarios add fixed expected values.
// ---------------------------------------------------------------------------
module tb_decode_pipe_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] pc_in;
    logic [31:0] instruction_in;
    logic [3:0]  src1_addr;
    logic [3:0]  src2_addr;
    logic [3:0]  dst_addr;
    logic        src1_used;
    logic        src2_used;
    logic [6:0]  ctrl_in;
    logic        wb_en_in;
    logic        mem_read_in;
    logic        condition_pass;
    logic        flush;
    logic        ex_ready;
    logic        mem_wb_en;
    logic [3:0]  mem_dst;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;

    logic        o_id_ready    [2];
    logic        o_hazard      [2];
    logic        o_ex_valid    [2];
    logic [31:0] o_ex_pc       [2];
    logic [31:0] o_ex_instr    [2];
    logic [31:0] o_ex_rn       [2];
    logic [31:0] o_ex_rm       [2];
    logic [3:0]  o_ex_dst      [2];
    logic [3:0]  o_ex_src1     [2];
    logic [3:0]  o_ex_src2     [2];
    logic [6:0]  o_ex_ctrl     [2];
    logic        o_ex_wb_en    [2];
    logic        o_ex_mem_read [2];

    int checks = 0;
    int errors = 0;

    decode_pipe_stage #(.FORWARDING_EN(1'b0)) dut_stall (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(o_id_ready[0]),
        .pc_in(pc_in), .instruction_in(instruction_in),
        .src1_addr(src1_addr), .src2_addr(src2_addr), .dst_addr(dst_addr),
        .src1_used(src1_used), .src2_used(src2_used), .ctrl_in(ctrl_in),
        .wb_en_in(wb_en_in), .mem_read_in(mem_read_in),
        .condition_pass(condition_pass), .flush(flush), .ex_ready(ex_ready),
        .mem_wb_en(mem_wb_en), .mem_dst(mem_dst),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(o_ex_valid[0]), .ex_pc(o_ex_pc[0]),
        .ex_instruction(o_ex_instr[0]), .ex_val_rn(o_ex_rn[0]),
        .ex_val_rm(o_ex_rm[0]), .ex_dst(o_ex_dst[0]), .ex_src1(o_ex_src1[0]),
        .ex_src2(o_ex_src2[0]), .ex_ctrl(o_ex_ctrl[0]),
        .ex_wb_en(o_ex_wb_en[0]), .ex_mem_read(o_ex_mem_read[0]),
        .hazard(o_hazard[0])
    );

    decode_pipe_stage #(.FORWARDING_EN(1'b1)) dut_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(o_id_ready[1]),
        .pc_in(pc_in), .instruction_in(instruction_in),
        .src1_addr(src1_addr), .src2_addr(src2_addr), .dst_addr(dst_addr),
        .src1_used(src1_used), .src2_used(src2_used), .ctrl_in(ctrl_in),
        .wb_en_in(wb_en_in), .mem_read_in(mem_read_in),
        .condition_pass(condition_pass), .flush(flush), .ex_ready(ex_ready),
        .mem_wb_en(mem_wb_en), .mem_dst(mem_dst),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(o_ex_valid[1]), .ex_pc(o_ex_pc[1]),
        .ex_instruction(o_ex_instr[1]), .ex_val_rn(o_ex_rn[1]),
        .ex_val_rm(o_ex_rm[1]), .ex_dst(o_ex_dst[1]), .ex_src1(o_ex_src1[1]),
        .ex_src2(o_ex_src2[1]), .ex_ctrl(o_ex_ctrl[1]),
        .ex_wb_en(o_ex_wb_en[1]), .ex_mem_read(o_ex_mem_read[1]),
        .hazard(o_hazard[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [31:0] m_rf   [16];
    logic        m_vld  [2];
    logic [31:0] m_pc   [2];
    logic [31:0] m_ins  [2];
    logic [31:0] m_rn   [2];
    logic [31:0] m_rm   [2];
    logic [3:0]  m_dst  [2];
    logic [3:0]  m_s1   [2];
    logic [3:0]  m_s2   [2];
    logic [6:0]  m_ctrl [2];
    logic        m_wb   [2];
    logic        m_mr   [2];

    task automatic model_reset();
        for (int r = 0; r < 16; r++) m_rf[r] = 32'h0;
        for (int k = 0; k < 2; k++) begin
            m_vld[k] = 0; m_pc[k] = 0; m_ins[k] = 0; m_rn[k] = 0; m_rm[k] = 0;
            m_dst[k] = 0; m_s1[k] = 0; m_s2[k] = 0; m_ctrl[k] = 0;
            m_wb[k] = 0; m_mr[k] = 0;
        end
    endtask

    function automatic logic model_hazard(int k);
        logic ex_hit;
        logic mem_hit;
        ex_hit  = 1'b0;
        mem_hit = 1'b0;
        if (m_vld[k] && m_wb[k])
            ex_hit = (src1_used && m_dst[k] == src1_addr) ||
                     (src2_used && m_dst[k] == src2_addr);
        if (mem_wb_en)
            mem_hit = (src1_used && mem_dst == src1_addr) ||
                      (src2_used && mem_dst == src2_addr);
        if (k == 0) return id_valid && (ex_hit || mem_hit);
        return id_valid && ex_hit && m_mr[k];
    endfunction

    function automatic logic model_ready(int k);
        return flush || ((!m_vld[k] || ex_ready) && !model_hazard(k));
    endfunction

    function automatic logic [31:0] model_read(logic [3:0] a);
        return (wb_en && wb_addr == a) ? wb_data : m_rf[a];
    endfunction

    task automatic model_clock();
        logic hz;
        for (int k = 0; k < 2; k++) begin
            hz = model_hazard(k);
            if (flush) begin
                m_vld[k] = 1'b0;
            end else if (!m_vld[k] || ex_ready) begin
                m_vld[k] = id_valid && !hz;
                if (m_vld[k]) begin
                    m_pc[k]   = pc_in;
                    m_ins[k]  = instruction_in;
                    m_rn[k]   = model_read(src1_addr);
                    m_rm[k]   = model_read(src2_addr);
                    m_dst[k]  = dst_addr;
                    m_s1[k]   = src1_addr;
                    m_s2[k]   = src2_addr;
                    m_ctrl[k] = condition_pass ? ctrl_in : 7'h0;
                    m_wb[k]   = condition_pass && wb_en_in;
                    m_mr[k]   = condition_pass && mem_read_in;
                end
            end
        end
        if (wb_en) m_rf[wb_addr] = wb_data;
    endtask

    function automatic logic [149:0] exp_bundle(int k);
        return {m_vld[k], m_pc[k], m_ins[k], m_rn[k], m_rm[k], m_dst[k],
                m_s1[k], m_s2[k], m_ctrl[k], m_wb[k], m_mr[k]};
    endfunction

    function automatic logic [149:0] obs_bundle(int k);
        return {o_ex_valid[k], o_ex_pc[k], o_ex_instr[k], o_ex_rn[k],
                o_ex_rm[k], o_ex_dst[k], o_ex_src1[k], o_ex_src2[k],
                o_ex_ctrl[k], o_ex_wb_en[k], o_ex_mem_read[k]};
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic [149:0] obs, input logic [149:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; pc_in = 0; instruction_in = 0;
        src1_addr = 0; src2_addr = 0; dst_addr = 0;
        src1_used = 0; src2_used = 0; ctrl_in = 0;
        wb_en_in = 0; mem_read_in = 0; condition_pass = 1;
        flush = 0; ex_ready = 1; mem_wb_en = 0; mem_dst = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [3:0] dst,
                         input logic wbi, input logic mri);
        id_valid = 1; pc_in = pc; instruction_in = pc ^ 32'hA5A5_0000;
        dst_addr = dst; wb_en_in = wbi; mem_read_in = mri; ctrl_in = 7'h15;
    endtask

    // Called at a falling edge with inputs set: checks the combinational
    // outputs, advances one clock, then checks the execute slot.
    task automatic step(input string tag);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk1($sformatf("%s.d%0d.hazard", tag, k), o_hazard[k], model_hazard(k));
            chk1($sformatf("%s.d%0d.id_ready", tag, k), o_id_ready[k], model_ready(k));
        end
        @(posedge clk);
        model_clock();
        #1;
        for (int k = 0; k < 2; k++)
            chkb($sformatf("%s.d%0d.ex", tag, k), obs_bundle(k), exp_bundle(k));
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        idle();
        #1 rst = 1'b0;
        model_reset();

        // Reset state
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chkb($sformatf("reset.d%0d.ex", k), obs_bundle(k), exp_bundle(k));
            chk1($sformatf("reset.d%0d.ex_valid", k), o_ex_valid[k], 1'b0);
            chk1($sformatf("reset.d%0d.hazard", k), o_hazard[k], 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Same-cycle write bypass
        idle();
        issue(32'h100, 4'd1, 1, 0);
        src1_addr = 4'd5; src1_used = 1;
        wb_en = 1; wb_addr = 4'd5; wb_data = 32'hDEAD;
        step("bypass");
        for (int k = 0; k < 2; k++) begin
            chk1($sformatf("bypass.d%0d.valid", k), o_ex_valid[k], 1'b1);
            chk32($sformatf("bypass.d%0d.rn", k), o_ex_rn[k], 32'hDEAD);
        end

        // RAW against EX then MEM writer
        idle();
        issue(32'h200, 4'd2, 1, 0);
        step("raw_a");
        idle();
        issue(32'h204, 4'd6, 1, 0);
        src2_addr = 4'd2; src2_used = 1;
        #1;
        chk1("raw_ex.d0.hazard", o_hazard[0], 1'b1);
        chk1("raw_ex.d0.id_ready", o_id_ready[0], 1'b0);
        chk1("raw_ex.d1.hazard", o_hazard[1], 1'b0);
        chk1("raw_ex.d1.id_ready", o_id_ready[1], 1'b1);
        step("raw_ex");
        mem_wb_en = 1; mem_dst = 4'd2;
        #1;
        chk1("raw_mem.d0.hazard", o_hazard[0], 1'b1);
        chk1("raw_mem.d1.hazard", o_hazard[1], 1'b0);
        step("raw_mem");
        mem_wb_en = 0;
        #1;
        chk1("raw_rel.d0.hazard", o_hazard[0], 1'b0);
        chk1("raw_rel.d0.id_ready", o_id_ready[0], 1'b1);
        step("raw_rel");
        chk32("raw_rel.d0.pc", o_ex_pc[0], 32'h204);

        // Load-use
        idle();
        issue(32'h300, 4'd2, 1, 1);
        step("load");
        idle();
        issue(32'h304, 4'd7, 1, 0);
        src2_addr = 4'd2; src2_used = 1;
        #1;
        chk1("lu1.d1.hazard", o_hazard[1], 1'b1);
        chk1("lu1.d1.id_ready", o_id_ready[1], 1'b0);
        step("lu1");
        mem_wb_en = 1; mem_dst = 4'd2;
        #1;
        chk1("lu2.d1.hazard", o_hazard[1], 1'b0);
        chk1("lu2.d1.id_ready", o_id_ready[1], 1'b1);
        step("lu2");
        chk32("lu2.d1.pc", o_ex_pc[1], 32'h304);
        mem_wb_en = 0;
        step("lu3");

        // Backpressure then flush
        idle();
        issue(32'h400, 4'd8, 0, 0);
        step("bp_load");
        issue(32'h404, 4'd8, 0, 0);
        ex_ready = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            for (int k = 0; k < 2; k++)
                chk1($sformatf("bp%0d.d%0d.id_ready", c, k), o_id_ready[k], 1'b0);
            step($sformatf("bp%0d", c));
            for (int k = 0; k < 2; k++)
                chk32($sformatf("bp%0d.d%0d.pc", c, k), o_ex_pc[k], 32'h400);
        end
        flush = 1;
        step("bp_flush");
        for (int k = 0; k < 2; k++)
            chk1($sformatf("bp_flush.d%0d.valid", k), o_ex_valid[k], 1'b0);

        // Condition failed
        idle();
        issue(32'h500, 4'd9, 1, 1);
        ctrl_in = 7'h7F; condition_pass = 0;
        step("cond");
        for (int k = 0; k < 2; k++) begin
            chk1($sformatf("cond.d%0d.valid", k), o_ex_valid[k], 1'b1);
            chk1($sformatf("cond.d%0d.wb_en", k), o_ex_wb_en[k], 1'b0);
            chk32($sformatf("cond.d%0d.ctrl", k), 32'(o_ex_ctrl[k]), 32'h0);
        end
        idle();
        issue(32'h504, 4'd10, 1, 0);
        src1_addr = 4'd9; src1_used = 1;
        #1;
        for (int k = 0; k < 2; k++)
            chk1($sformatf("cond_dep.d%0d.hazard", k), o_hazard[k], 1'b0);
        step("cond_dep");

        // Asynchronous reset mid-cycle clears the slot and register file
        idle();
        issue(32'h600, 4'd11, 1, 0);
        wb_en = 1; wb_addr = 4'd3; wb_data = 32'h55;
        step("pre_rst");
        chk1("pre_rst.d0.valid", o_ex_valid[0], 1'b1);
        idle();
        #2 rst = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            chk1($sformatf("async_rst.d%0d.valid", k), o_ex_valid[k], 1'b0);
            chkb($sformatf("async_rst.d%0d.ex", k), obs_bundle(k), exp_bundle(k));
        end
        @(negedge clk);
        rst = 1'b1;
        issue(32'h700, 4'd12, 0, 0);
        src1_addr = 4'd3; src1_used = 1;
        step("post_rst");
        chk1("post_rst.d0.valid", o_ex_valid[0], 1'b1);
        chk32("post_rst.d0.rn", o_ex_rn[0], 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            id_valid       = ($urandom_range(0, 3) != 0);
            pc_in          = 32'($urandom);
            instruction_in = 32'($urandom);
            src1_addr      = 4'($urandom_range(0, 3));
            src2_addr      = 4'($urandom_range(0, 3));
            dst_addr       = 4'($urandom_range(0, 3));
            src1_used      = 1'($urandom_range(0, 1));
            src2_used      = 1'($urandom_range(0, 1));
            ctrl_in        = 7'($urandom);
            wb_en_in       = 1'($urandom_range(0, 1));
            mem_read_in    = ($urandom_range(0, 2) == 0);
            condition_pass = ($urandom_range(0, 7) != 0);
            flush          = ($urandom_range(0, 15) == 0);
            ex_ready       = ($urandom_range(0, 3) != 0);
            mem_wb_en      = 1'($urandom_range(0, 1));
            mem_dst        = 4'($urandom_range(0, 3));
            wb_en          = 1'($urandom_range(0, 1));
            wb_addr        = 4'($urandom_range(0, 3));
            wb_data        = 32'($urandom);
            step($sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
